// File: rtl/pal_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_loader_pkg
// Brief    : Shared PAL sizing, loader types and loader state encoding.
// Revision : 1.0
// ============================================================================
package pal_cfg_loader_pkg;

    localparam int C_N_IN    = 8;
    localparam int C_P_TERMS = 14;
    localparam int C_M_OUT   = 4;

    localparam int C_BYTE_BITS = 8;
    localparam int C_REM_W     = 4;

    typedef logic [C_BYTE_BITS-1:0] byte_t;
    typedef logic [C_REM_W-1:0]     rem_t;

    localparam rem_t C_REM_BYTE = rem_t'(C_BYTE_BITS);

    // AND-plane holds true and complement literals per input per term.
    function automatic int cfg_bits_calc(input int n_in, input int p_terms, input int m_out);
        return 2 * n_in * p_terms + p_terms * m_out;
    endfunction

    localparam int C_CFG_BITS = cfg_bits_calc(C_N_IN, C_P_TERMS, C_M_OUT);

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_APPLY = 1'b1
    } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/pal_cfg_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_serializer
// Brief    : Byte-in, LSB-first bit-and-strobe-out shifter with bit budget.
// Revision : 1.0
// ============================================================================
module pal_cfg_serializer
    import pal_cfg_loader_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clear_i,
    input  logic  load_i,
    input  byte_t data_i,
    input  rem_t  nbits_i,
    output logic  bit_o,
    output logic  strobe_o,
    output rem_t  rem_o
);

    byte_t shift_q, shift_d;
    rem_t  rem_q, rem_d;

    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        if (clear_i) begin
            shift_d = '0;
            rem_d   = '0;
        end else if (load_i) begin
            // A load may coincide with the last strobe of the previous byte.
            shift_d = data_i;
            rem_d   = nbits_i;
        end else if (rem_q != '0) begin
            shift_d = {1'b0, shift_q[C_BYTE_BITS-1:1]};
            rem_d   = rem_q - rem_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end

    assign strobe_o = (rem_q != '0);
    assign bit_o    = strobe_o & shift_q[0];
    assign rem_o    = rem_q;

endmodule
`default_nettype wire

// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_loader
// Brief    : Loads CFG_BITS serial config bits into the PAL, then applies.
// Revision : 1.0
// ============================================================================
module pal_cfg_loader
    import pal_cfg_loader_pkg::*;
#(
    parameter  int CFG_BITS = C_CFG_BITS,
    localparam int CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             RESTART,
    input  logic [7:0]       DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic             CFG_BIT,
    output logic             CFG_STROBE,
    output logic             CFG_APPLY,
    output logic [CNT_W-1:0] BIT_COUNT
);

    localparam logic [CNT_W:0] C_TOTAL = (CNT_W + 1)'(CFG_BITS);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    rem_t           w_rem;
    rem_t           w_nbits;
    logic [CNT_W:0] w_used;
    logic [CNT_W:0] w_left;
    logic           w_strobe;
    logic           w_bit;
    logic           w_ready;
    logic           w_accept;

    // Bits already committed once this cycle ends: shifted so far plus in flight.
    assign w_used   = {1'b0, count_q} + (CNT_W + 1)'(w_rem);
    assign w_left   = C_TOTAL - w_used;
    assign w_nbits  = (w_left >= (CNT_W + 1)'(C_BYTE_BITS)) ? C_REM_BYTE : rem_t'(w_left);
    assign w_ready  = (state_q == ST_LOAD) && !RESTART && (w_rem <= rem_t'(1)) && (w_used < C_TOTAL);
    assign w_accept = w_ready && DATA_VALID;

    pal_cfg_serializer u_ser (
        .clk_i    (CLK),
        .rst_ni   (RES_N),
        .clear_i  (RESTART),
        .load_i   (w_accept),
        .data_i   (DATA_IN),
        .nbits_i  (w_nbits),
        .bit_o    (w_bit),
        .strobe_o (w_strobe),
        .rem_o    (w_rem)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (RESTART) begin
            state_d = ST_LOAD;
            count_d = '0;
        end else begin
            if (w_strobe) begin
                count_d = count_q + CNT_W'(1);
            end
            if ((state_q == ST_LOAD) && ({1'b0, count_d} == C_TOTAL)) begin
                state_d = ST_APPLY;
            end
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= ST_LOAD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign DATA_READY = w_ready;
    assign CFG_BIT    = w_bit;
    assign CFG_STROBE = w_strobe;
    assign CFG_APPLY  = (state_q == ST_APPLY);
    assign BIT_COUNT  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pal_cfg_loader
// Brief    : Self-checking bench for pal_cfg_loader (280-bit and 12-bit builds).
// Revision : 1.0
// ============================================================================
module tb_pal_cfg_loader;

    logic       CLK = 1'b0;
    logic       RES_N;
    logic       restart [2];
    logic [7:0] din     [2];
    logic       valid   [2];
    logic       rdy_o   [2];
    logic       bit_o   [2];
    logic       stb_o   [2];
    logic       app_o   [2];
    logic [8:0] cnt0;
    logic [3:0] cnt1;

    always #5 CLK = ~CLK;

    pal_cfg_loader dut0 (
        .CLK(CLK), .RES_N(RES_N), .RESTART(restart[0]), .DATA_IN(din[0]),
        .DATA_VALID(valid[0]), .DATA_READY(rdy_o[0]), .CFG_BIT(bit_o[0]),
        .CFG_STROBE(stb_o[0]), .CFG_APPLY(app_o[0]), .BIT_COUNT(cnt0)
    );

    pal_cfg_loader #(.CFG_BITS(12)) dut1 (
        .CLK(CLK), .RES_N(RES_N), .RESTART(restart[1]), .DATA_IN(din[1]),
        .DATA_VALID(valid[1]), .DATA_READY(rdy_o[1]), .CFG_BIT(bit_o[1]),
        .CFG_STROBE(stb_o[1]), .CFG_APPLY(app_o[1]), .BIT_COUNT(cnt1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s [dut%0d]: got %0d, expected %0d", nm, k, act, exp);
        else n_pass++;
    endtask

    // Model: a list of bits still owed to the PAL, a shifted-bit total and an applied flag.
    int        m_cnt   [2];
    int        m_npend [2];
    int        m_acc   [2];
    int        m_first [2];
    bit [15:0] m_pend  [2];
    bit        m_app   [2];
    int        cyc = 0;

    function automatic int tot(input int k);
        return (k == 0) ? 280 : 12;
    endfunction

    function automatic bit m_ready(input int k);
        return !m_app[k] && !restart[k] && (m_npend[k] <= 1) && (m_cnt[k] + m_npend[k] < tot(k));
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or negedge RES_N) begin
        bit mr;
        int mn;
        for (int k = 0; k < 2; k++) begin
            if (!RES_N || restart[k]) begin
                m_cnt[k] = 0; m_npend[k] = 0; m_pend[k] = '0; m_app[k] = 0;
            end else begin
                mr = m_ready(k);
                if (valid[k] && mr && m_cnt[k] == 0 && m_npend[k] == 0) m_first[k] = cyc;
                if (m_npend[k] > 0) begin
                    m_pend[k] = m_pend[k] >> 1;
                    m_npend[k]--;
                    m_cnt[k]++;
                end
                if (valid[k] && mr) begin
                    mn = tot(k) - m_cnt[k] - m_npend[k];
                    if (mn > 8) mn = 8;
                    m_pend[k] = m_pend[k] | ((16'(din[k]) & ((16'd1 << mn) - 16'd1)) << m_npend[k]);
                    m_npend[k] += mn;
                    m_acc[k]++;
                end
                if (m_cnt[k] == tot(k)) m_app[k] = 1;
            end
        end
    end

    int n_stb    [2];
    int n_ones   [2];
    int app_cyc  [2];
    bit prev_app [2];
    bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int pidx  = 0;
    bit in_t1 = 0;

    always @(negedge CLK) begin
        bit e_stb;
        bit e_bit;
        for (int k = 0; k < 2; k++) begin
            e_stb = (m_npend[k] > 0);
            e_bit = e_stb && m_pend[k][0];
            chk("ready",  k, rdy_o[k], m_ready(k));
            chk("strobe", k, stb_o[k], e_stb);
            chk("bit",    k, bit_o[k], e_bit);
            chk("apply",  k, app_o[k], m_app[k]);
            chk("count",  k, (k == 0) ? 32'(cnt0) : 32'(cnt1), m_cnt[k]);
            if (stb_o[k] === 1'b1) begin
                n_stb[k]++;
                if (bit_o[k] === 1'b1) n_ones[k]++;
            end
            if (app_o[k] === 1'b1 && !prev_app[k]) app_cyc[k] = cyc;
            prev_app[k] = (app_o[k] === 1'b1);
        end
        if (in_t1 && stb_o[0] === 1'b1) begin
            chk("t1_pattern", 0, bit_o[0], pat[pidx % 8]);
            pidx++;
        end
    end

    task automatic send_byte(input int k, input logic [7:0] b);
        int a0;
        int i;
        a0 = m_acc[k]; din[k] = b; valid[k] = 1'b1; i = 0;
        do begin
            @(posedge CLK); #1; i++;
        end while (m_acc[k] == a0 && i < 100);
        valid[k] = 1'b0;
        if (m_acc[k] == a0) chk("accept_timeout", k, 0, 1);
    endtask

    task automatic wait_apply(input int k, input int lim);
        int i;
        i = 0;
        while (app_o[k] !== 1'b1 && i < lim) begin
            @(posedge CLK); #1; i++;
        end
        if (app_o[k] !== 1'b1) chk("apply_timeout", k, 0, 1);
    endtask

    task automatic do_restart(input int k);
        restart[k] = 1'b1;
        @(posedge CLK); #1;
        restart[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, o0, i;
        bit [7:0] gb [5] = '{8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A};
        RES_N = 1'b0;
        for (int k = 0; k < 2; k++) begin
            restart[k] = 1'b0; din[k] = 8'h00; valid[k] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready",  0, rdy_o[0], 1);
        chk("rst_strobe", 0, stb_o[0], 0);
        chk("rst_bit",    0, bit_o[0], 0);
        chk("rst_apply",  0, app_o[0], 0);
        chk("rst_count",  0, cnt0, 0);
        chk("rst_count",  1, cnt1, 0);
        RES_N = 1'b1;
        @(posedge CLK); #1;

        // 12-bit build: second byte only contributes its low nibble.
        s0 = n_stb[1]; o0 = n_ones[1];
        send_byte(1, 8'hFF);
        send_byte(1, 8'h0F);
        chk("t2_ready_after_2nd", 1, rdy_o[1], 0);
        repeat (8) @(posedge CLK);
        #1;
        chk("t2_strobes", 1, n_stb[1] - s0, 12);
        chk("t2_ones",    1, n_ones[1] - o0, 12);
        chk("t2_apply",   1, app_o[1], 1);
        chk("t2_count",   1, cnt1, 12);

        // Full 280-bit load with VALID held high.
        s0 = n_stb[0]; o0 = m_acc[0]; pidx = 0; in_t1 = 1;
        din[0] = 8'hA5; valid[0] = 1'b1;
        wait_apply(0, 400);
        @(posedge CLK); #1;
        valid[0] = 1'b0; in_t1 = 0;
        chk("t1_strobes", 0, n_stb[0] - s0, 280);
        chk("t1_pattern_len", 0, pidx, 280);
        chk("t1_latency", 0, app_cyc[0] - m_first[0], 281);
        chk("t1_bytes",   0, m_acc[0] - o0, 35);
        chk("t1_count",   0, cnt0, 280);

        // Bytes offered while applied are ignored.
        s0 = n_stb[0]; din[0] = 8'h33; valid[0] = 1'b1;
        repeat (10) begin
            @(posedge CLK); #1;
        end
        chk("t5_ready",   0, rdy_o[0], 0);
        valid[0] = 1'b0;
        chk("t5_strobes", 0, n_stb[0] - s0, 0);
        chk("t5_apply",   0, app_o[0], 1);
        chk("t5_count",   0, cnt0, 280);

        // Sparse bytes, one every 20 cycles.
        do_restart(0);
        chk("t3_restart_count", 0, cnt0, 0);
        chk("t3_restart_apply", 0, app_o[0], 0);
        s0 = n_stb[0]; o0 = n_ones[0];
        for (int b = 0; b < 5; b++) begin
            send_byte(0, gb[b]);
            repeat (12) @(posedge CLK);
            #1;
            chk("t3_gap_strobe", 0, stb_o[0], 0);
            chk("t3_gap_bit",    0, bit_o[0], 0);
            repeat (7) @(posedge CLK);
            #1;
        end
        chk("t3_strobes", 0, n_stb[0] - s0, 40);
        chk("t3_ones",    0, n_ones[0] - o0, 18);
        chk("t3_count",   0, cnt0, 40);

        // Restart mid-load while a byte is being offered and would be accepted.
        do_restart(0);
        din[0] = 8'hC3; valid[0] = 1'b1; i = 0;
        while (m_cnt[0] < 103 && i < 200) begin
            @(posedge CLK); #1; i++;
        end
        chk("t4_count_before", 0, cnt0, 103);
        restart[0] = 1'b1;
        @(posedge CLK); #1;
        restart[0] = 1'b0;
        chk("t4_count_clr",  0, cnt0, 0);
        chk("t4_apply_clr",  0, app_o[0], 0);
        chk("t4_no_strobe",  0, stb_o[0], 0);
        s0 = n_stb[0];
        wait_apply(0, 400);
        @(posedge CLK); #1;
        valid[0] = 1'b0;
        chk("t4_strobes", 0, n_stb[0] - s0, 280);
        chk("t4_count",   0, cnt0, 280);

        // Asynchronous reset with four bits of a byte still owed.
        do_restart(0);
        send_byte(0, 8'h96);
        repeat (4) @(posedge CLK);
        #3;
        RES_N = 1'b0;
        #1;
        chk("t6_strobe", 0, stb_o[0], 0);
        chk("t6_bit",    0, bit_o[0], 0);
        chk("t6_apply",  0, app_o[0], 0);
        chk("t6_count",  0, cnt0, 0);
        s0 = n_stb[0];
        @(posedge CLK); #1;
        RES_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        chk("t6_no_strobes", 0, n_stb[0] - s0, 0);
        chk("t6_ready",      0, rdy_o[0], 1);
        chk("t6_count_idle", 0, cnt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
